// File: rtl/serial_pkg.sv
// Shared encodings for the serial receiver: parity modes and FSM states.
package serial_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        sIdle,
        sStartCheck,
        sData,
        sParity,
        sStop,
        sErrorRecovery
    } rxState_t;

endpackage

// File: rtl/configurable_serial_receiver_if.sv
// Line input and frame-report outputs of the serial receiver.
interface serial_rx_if #(
    parameter int DataBits = 8
) ();

    logic                iRXD;
    logic [DataBits-1:0] oData;
    logic                oReceived;
    logic                oParityError;
    logic                oFramingError;
    logic                oBreak;
    logic                oBusy;

    modport master (
        input  iRXD,
        output oData,
        output oReceived,
        output oParityError,
        output oFramingError,
        output oBreak,
        output oBusy
    );

    modport slave (
        output iRXD,
        input  oData,
        input  oReceived,
        input  oParityError,
        input  oFramingError,
        input  oBreak,
        input  oBusy
    );

endinterface

// File: rtl/serial_rx_sampler.sv
// Two-flop line synchroniser plus a 2-of-3 vote over the last three samples.
module serial_rx_sampler (
    input  logic iClock,
    input  logic iReset,
    input  logic iRXD,
    output logic oRxd,
    output logic oVote
);

    logic [1:0] sync;
    logic [1:0] hist;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            sync <= 2'b11;
            hist <= 2'b11;
        end else begin
            sync <= {sync[0], iRXD};
            hist <= {hist[0], sync[1]};
        end
    end

    // oRxd is centre+1 when the FSM decides, hist holds centre and centre-1
    assign oRxd  = sync[1];
    assign oVote = (oRxd & hist[0]) | (oRxd & hist[1])
                 | (hist[0] & hist[1]);

endmodule

// File: rtl/configurable_serial_receiver.sv
// Configurable UART receiver; define SERIAL_RX_BREAK_DETECT_EN to report
// all-zero frames on oBreak instead of as framing errors.
module configurable_serial_receiver
    import serial_pkg::*;
#(
    parameter int ClockFrequency = 16000000,
    parameter int BaudRate       = 115200,
    parameter int DataBits       = 8,
    parameter int ParityMode     = 0,
    parameter int StopBits       = 1
) (
    input logic       iClock,
    input logic       iReset,
    serial_rx_if.master rx
);

    localparam int TicksPerBit = ClockFrequency / BaudRate;
    localparam int TimerMax    = TicksPerBit + TicksPerBit / 2;
    localparam int TimerWidth  = $clog2(TimerMax + 1);
    localparam int CountWidth  = $clog2(DataBits);

    localparam logic [TimerWidth-1:0] StartTick =
        TimerWidth'(TicksPerBit / 2 + 1);
    localparam logic [TimerWidth-1:0] BitTick =
        TimerWidth'(TicksPerBit - 1);
    localparam logic [CountWidth-1:0] LastData =
        CountWidth'(DataBits - 1);
    localparam logic [CountWidth-1:0] LastStop =
        CountWidth'(StopBits - 1);

    if (TicksPerBit < 8) begin : gBadRate
        $error("ClockFrequency/BaudRate must be >= 8");
    end
    if (DataBits < 5 || DataBits > 9) begin : gBadData
        $error("DataBits must be 5..9");
    end
    if (StopBits < 1 || StopBits > 2) begin : gBadStop
        $error("StopBits must be 1 or 2");
    end
    if (ParityMode < 0 || ParityMode > 2) begin : gBadParity
        $error("ParityMode must be 0, 1 or 2");
    end

    logic rxd;
    logic vote;

    serial_rx_sampler uSampler (
        .iClock (iClock),
        .iReset (iReset),
        .iRXD   (rx.iRXD),
        .oRxd   (rxd),
        .oVote  (vote)
    );

    rxState_t              state,     stateNext;
    logic [TimerWidth-1:0] timer,     timerNext;
    logic [CountWidth-1:0] count,     countNext;
    logic [DataBits-1:0]   shift,     shiftNext;
    logic [DataBits-1:0]   dataQ,     dataD;
    logic                  parityBit, parityBitNext;
    logic                  stopBad,   stopBadNext;
    logic                  anyOne,    anyOneNext;
    logic                  rcvQ,      rcvD;
    logic                  parErrQ,   parErrD;
    logic                  frmErrQ,   frmErrD;
    logic                  brkQ,      brkD;

    logic lastBad;
    logic lastAny;
    logic parityErr;
    logic isBreak;

    assign lastBad = stopBad | ~vote;
    assign lastAny = anyOne | vote;

    assign parityErr =
        (ParityMode == PARITY_EVEN) ?  (^shift ^ parityBit) :
        (ParityMode == PARITY_ODD)  ? ~(^shift ^ parityBit) :
        1'b0;

`ifdef SERIAL_RX_BREAK_DETECT_EN
    assign isBreak = ~lastAny;
`else
    assign isBreak = 1'b0;
`endif

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state     <= sIdle;
            timer     <= '0;
            count     <= '0;
            shift     <= '0;
            dataQ     <= '0;
            parityBit <= 1'b0;
            stopBad   <= 1'b0;
            anyOne    <= 1'b0;
            rcvQ      <= 1'b0;
            parErrQ   <= 1'b0;
            frmErrQ   <= 1'b0;
            brkQ      <= 1'b0;
        end else begin
            state     <= stateNext;
            timer     <= timerNext;
            count     <= countNext;
            shift     <= shiftNext;
            dataQ     <= dataD;
            parityBit <= parityBitNext;
            stopBad   <= stopBadNext;
            anyOne    <= anyOneNext;
            rcvQ      <= rcvD;
            parErrQ   <= parErrD;
            frmErrQ   <= frmErrD;
            brkQ      <= brkD;
        end
    end

    always_comb begin
        stateNext     = state;
        timerNext     = timer + 1'b1;
        countNext     = count;
        shiftNext     = shift;
        dataD         = dataQ;
        parityBitNext = parityBit;
        stopBadNext   = stopBad;
        anyOneNext    = anyOne;
        rcvD          = 1'b0;
        parErrD       = 1'b0;
        frmErrD       = 1'b0;
        brkD          = 1'b0;

        unique case (state)
            sIdle: begin
                timerNext = '0;
                countNext = '0;
                if (!rxd) begin
                    stateNext   = sStartCheck;
                    stopBadNext = 1'b0;
                    anyOneNext  = 1'b0;
                end
            end
            sStartCheck: begin
                if (timer == StartTick) begin
                    timerNext = '0;
                    stateNext = vote ? sIdle : sData;
                end
            end
            sData: begin
                if (timer == BitTick) begin
                    timerNext  = '0;
                    shiftNext  = {vote, shift[DataBits-1:1]};
                    anyOneNext = lastAny;
                    if (count == LastData) begin
                        countNext = '0;
                        stateNext = (ParityMode != PARITY_NONE)
                                  ? sParity : sStop;
                    end else begin
                        countNext = count + 1'b1;
                    end
                end
            end
            sParity: begin
                if (timer == BitTick) begin
                    timerNext     = '0;
                    parityBitNext = vote;
                    anyOneNext    = lastAny;
                    stateNext     = sStop;
                end
            end
            sStop: begin
                if (timer == BitTick) begin
                    timerNext   = '0;
                    stopBadNext = lastBad;
                    anyOneNext  = lastAny;
                    if (count == LastStop) begin
                        countNext = '0;
                        dataD     = shift;
                        if (isBreak) begin
                            brkD      = 1'b1;
                            stateNext = sErrorRecovery;
                        end else begin
                            frmErrD   = lastBad;
                            parErrD   = parityErr;
                            rcvD      = ~lastBad & ~parityErr;
                            stateNext = lastBad ? sErrorRecovery : sIdle;
                        end
                    end else begin
                        countNext = count + 1'b1;
                    end
                end
            end
            sErrorRecovery: begin
                timerNext = '0;
                if (rxd) begin
                    stateNext = sIdle;
                end
            end
            default: stateNext = sIdle;
        endcase
    end

    assign rx.oData         = dataQ;
    assign rx.oReceived     = rcvQ;
    assign rx.oParityError  = parErrQ;
    assign rx.oFramingError = frmErrQ;
    assign rx.oBreak        = brkQ;
    assign rx.oBusy         = (state != sIdle);

endmodule

// File: tb/tb_configurable_serial_receiver.sv
// Bench for configurable_serial_receiver: an 8N1 and a 7E2 instance.
module tb_configurable_serial_receiver;

    localparam int TPB = 138;

    typedef struct packed {
        logic [8:0] data;
        logic       rx;
        logic       par;
        logic       frm;
        logic       brk;
    } exp_t;

    typedef struct {
        int         sel;
        logic [8:0] data;
        logic       par;
        logic [1:0] stops;
        exp_t       exp;
    } vec_t;

    logic iClock = 1'b0;
    logic iReset = 1'b1;
    logic rxd8   = 1'b1;
    logic rxd7   = 1'b1;

    int checks = 0;
    int errors = 0;

    exp_t q8[$];
    exp_t q7[$];

    always #5 iClock = ~iClock;

    serial_rx_if #(.DataBits(8)) if8 ();
    serial_rx_if #(.DataBits(7)) if7 ();

    assign if8.iRXD = rxd8;
    assign if7.iRXD = rxd7;

    configurable_serial_receiver #(
        .ClockFrequency (16000000),
        .BaudRate       (115200),
        .DataBits       (8),
        .ParityMode     (0),
        .StopBits       (1)
    ) dut8 (
        .iClock (iClock),
        .iReset (iReset),
        .rx     (if8.master)
    );

    configurable_serial_receiver #(
        .ClockFrequency (16000000),
        .BaudRate       (115200),
        .DataBits       (7),
        .ParityMode     (1),
        .StopBits       (2)
    ) dut7 (
        .iClock (iClock),
        .iReset (iReset),
        .rx     (if7.master)
    );

    // Scoreboard: every pulse must match the oldest expected frame
    always @(negedge iClock) begin
        exp_t e;
        exp_t g;
        if (if8.oReceived | if8.oParityError |
            if8.oFramingError | if8.oBreak) begin
            g = {1'b0, if8.oData, if8.oReceived, if8.oParityError,
                 if8.oFramingError, if8.oBreak};
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL dut8_unexpected got=%h", g);
            end else begin
                e = q8.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL dut8_frame got=%h want=%h", g, e);
                end
            end
        end
        if (if7.oReceived | if7.oParityError |
            if7.oFramingError | if7.oBreak) begin
            g = {2'b0, if7.oData, if7.oReceived, if7.oParityError,
                 if7.oFramingError, if7.oBreak};
            checks++;
            if (q7.size() == 0) begin
                errors++;
                $display("FAIL dut7_unexpected got=%h", g);
            end else begin
                e = q7.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL dut7_frame got=%h want=%h", g, e);
                end
            end
        end
    end

    task automatic driveBit(input int sel, input logic v, input int n);
        if (sel == 0) rxd8 = v;
        else          rxd7 = v;
        repeat (n) @(negedge iClock);
    endtask

    task automatic sendFrame(input int sel, input logic [8:0] data,
                             input logic par, input logic [1:0] stops);
        int nd;
        int ns;
        logic low;
        nd  = (sel == 0) ? 8 : 7;
        ns  = (sel == 0) ? 1 : 2;
        low = 1'b0;
        driveBit(sel, 1'b0, TPB);
        for (int i = 0; i < nd; i++) driveBit(sel, data[i], TPB);
        if (sel != 0) driveBit(sel, par, TPB);
        for (int i = 0; i < ns; i++) begin
            driveBit(sel, stops[i], TPB);
            if (!stops[i]) low = 1'b1;
        end
        if (low) driveBit(sel, 1'b0, TPB);
        driveBit(sel, 1'b1, 2 * TPB);
    endtask

    task automatic checkDrained(input int sel, input string name);
        int n;
        n = (sel == 0) ? q8.size() : q7.size();
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL %s pending=%0d want=0", name, n);
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] got,
                            input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[11];
        exp_t brkExp;

        vecs[0]  = '{0, 9'h0A5, 1'b0, 2'b11, '{9'h0A5, 1, 0, 0, 0}};
        vecs[1]  = '{0, 9'h000, 1'b0, 2'b11, '{9'h000, 1, 0, 0, 0}};
        vecs[2]  = '{0, 9'h0FF, 1'b0, 2'b11, '{9'h0FF, 1, 0, 0, 0}};
        vecs[3]  = '{0, 9'h03C, 1'b0, 2'b10, '{9'h03C, 0, 0, 1, 0}};
        vecs[4]  = '{0, 9'h055, 1'b0, 2'b11, '{9'h055, 1, 0, 0, 0}};
        vecs[5]  = '{1, 9'h041, 1'b1, 2'b11, '{9'h041, 0, 1, 0, 0}};
        vecs[6]  = '{1, 9'h041, 1'b0, 2'b11, '{9'h041, 1, 0, 0, 0}};
        vecs[7]  = '{1, 9'h007, 1'b1, 2'b11, '{9'h007, 1, 0, 0, 0}};
        vecs[8]  = '{1, 9'h012, 1'b0, 2'b01, '{9'h012, 0, 0, 1, 0}};
        vecs[9]  = '{1, 9'h012, 1'b1, 2'b00, '{9'h012, 0, 1, 1, 0}};
        vecs[10] = '{1, 9'h07F, 1'b1, 2'b11, '{9'h07F, 1, 0, 0, 0}};

        repeat (3) @(negedge iClock);
        checkVal("reset8", {if8.oData, if8.oReceived, if8.oParityError,
                 if8.oFramingError, if8.oBreak, if8.oBusy}, 0);
        checkVal("reset7", {if7.oData, if7.oReceived, if7.oParityError,
                 if7.oFramingError, if7.oBreak, if7.oBusy}, 0);
        iReset = 1'b0;
        repeat (10) @(negedge iClock);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].sel == 0) q8.push_back(vecs[i].exp);
            else                  q7.push_back(vecs[i].exp);
            sendFrame(vecs[i].sel, vecs[i].data,
                      vecs[i].par, vecs[i].stops);
            checkDrained(vecs[i].sel, $sformatf("drain_vec%0d", i));
        end

        // Glitch shorter than half a bit is rejected at the start check
        driveBit(0, 1'b0, 40);
        checkVal("glitch_busy_hi", {31'b0, if8.oBusy}, 1);
        driveBit(0, 1'b1, TPB);
        checkVal("glitch_busy_lo", {31'b0, if8.oBusy}, 0);

        // Long low line: a break frame
`ifdef SERIAL_RX_BREAK_DETECT_EN
        brkExp = '{9'h000, 0, 0, 0, 1};
`else
        brkExp = '{9'h000, 0, 0, 1, 0};
`endif
        q8.push_back(brkExp);
        driveBit(0, 1'b0, 12 * TPB);
        driveBit(0, 1'b1, 2 * TPB);
        checkDrained(0, "drain_break");
        checkVal("break_busy_lo", {31'b0, if8.oBusy}, 0);

        q8.push_back('{9'h05A, 1, 0, 0, 0});
        sendFrame(0, 9'h05A, 1'b0, 2'b11);
        checkDrained(0, "drain_5a");

        // Reset in the middle of data bit 4
        driveBit(0, 1'b0, 5 * TPB + 60);
        checkVal("mid_busy", {31'b0, if8.oBusy}, 1);
        iReset = 1'b1;
        rxd8   = 1'b1;
        #1;
        checkVal("mid_reset", {if8.oData, if8.oReceived,
                 if8.oParityError, if8.oFramingError,
                 if8.oBreak, if8.oBusy}, 0);
        repeat (5) @(negedge iClock);
        iReset = 1'b0;
        driveBit(0, 1'b1, 2 * TPB);
        checkDrained(0, "drain_abort");

        q8.push_back('{9'h0FF, 1, 0, 0, 0});
        sendFrame(0, 9'h0FF, 1'b0, 2'b11);
        checkDrained(0, "drain_ff");
        checkVal("final_data", {24'b0, if8.oData}, 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
